// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
//
// Show-ahead (first-word-fall-through) sample buffer between the ADC /
// processing path and the upsampling interpolator. The head sample is always
// visible on dout, and the interpolator pops it with a one-cycle rd_en pulse.
// When the buffer is empty, dout carries mid-scale (analog zero for
// offset-binary samples) so the interpolator never replays stale data.
//
// Parameters
//   DATA_WIDTH  sample width, unsigned offset-binary (default 14)
//   ADDR_WIDTH  log2 of the depth; depth = 1 << ADDR_WIDTH (default 32 words)
//
// Ports
//   clk         single clock for all logic
//   rst_n       asynchronous active-low reset
//   wr_en       write request, one sample per cycle
//   din         sample to write
//   rd_en       pop request from the interpolator
//   dout        head sample (show-ahead), or mid-scale while empty
//   empty       no words stored
//   full        depth words stored
//   above_half  count >= depth/2; drives the interpolator's ena input
//   count       number of words stored, 0..depth
//
// Optional build macro SAMPLE_FIFO_ERR_EN adds two sticky status outputs:
//   ovf_err     a write was dropped because the buffer was full
//   udf_err     an rd_en arrived while the buffer was empty
// Both flags are cleared only by rst_n.
// ---------------------------------------------------------------------------
module sample_fifo #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  above_half,
  output logic [ADDR_WIDTH:0]   count
`ifdef SAMPLE_FIFO_ERR_EN
  ,
  output logic                  ovf_err,
  output logic                  udf_err
`endif
);

  // Constants are built by concatenation so each one has exactly the width
  // of the signal it is compared against or assigned to.
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   HALF_CNT  = {2'b01, {(ADDR_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MIDSCALE  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  rd_ok;
  logic                  wr_ok;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // A read while empty is ignored. A write while full is accepted only when
  // an accepted read in the same cycle frees a slot.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // Show-ahead output: the word under rd_ptr, or analog zero when nothing is
  // stored, so an underrun produces silence rather than a repeated sample.
  assign dout = empty ? MIDSCALE : mem[rd_ptr];

  // Next occupancy. A simultaneous accepted read and write cancel out.
  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok) begin
      count_next = count + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers, occupancy and the half-full flag. above_half is registered from
  // count_next, so it changes on the same edge as count, with no extra lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      above_half <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count      <= count_next;
      above_half <= (count_next >= HALF_CNT);
    end
  end

  // Sample storage has no reset; stale contents are unreachable once count
  // is zero. The rst_n term blocks writes while reset is held.
  always_ff @(posedge clk) begin
    if (wr_ok && rst_n) begin
      mem[wr_ptr] <= din;
    end
  end

`ifdef SAMPLE_FIFO_ERR_EN
  // Sticky error flags. An rd_en while empty counts as an underflow even when
  // a write is accepted in the same cycle, because that read is still ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) begin
        ovf_err <= 1'b1;
      end
      if (rd_en && empty) begin
        udf_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_sample_fifo
//
// Directed testbench for sample_fifo with the default parameters
// (DATA_WIDTH=14, ADDR_WIDTH=5, depth 32). Each task covers one scenario and
// checks its own hand-computed expectations. Inputs are driven 1 ns after the
// rising edge, and outputs are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_sample_fifo;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [13:0] din;
  logic        rd_en;
  logic [13:0] dout;
  logic        empty;
  logic        full;
  logic        above_half;
  logic [5:0]  count;
`ifdef SAMPLE_FIFO_ERR_EN
  logic        ovf_err;
  logic        udf_err;
`endif

  int tests_run;
  int tests_failed;

  sample_fifo #(
    .DATA_WIDTH(14),
    .ADDR_WIDTH(5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .din        (din),
    .rd_en      (rd_en),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .above_half (above_half),
    .count      (count)
`ifdef SAMPLE_FIFO_ERR_EN
    ,
    .ovf_err    (ovf_err),
    .udf_err    (udf_err)
`endif
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clears the FIFO between scenarios so each one starts from a known state
  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    tick();
    tick();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    tests_run++; if (above_half !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_above_half: got %b expected 0", above_half); end
    tests_run++; if (count !== 6'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    tests_run++; if (dout !== 14'h2000) begin tests_failed++; $display("[TB] FAIL reset_dout: got %h expected 2000", dout); end
`ifdef SAMPLE_FIFO_ERR_EN
    tests_run++; if (ovf_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ovf_err: got %b expected 0", ovf_err); end
    tests_run++; if (udf_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_udf_err: got %b expected 0", udf_err); end
`endif
    // Release and idle: still empty with no traffic
    rst_n = 1'b1;
    tick();
    tick();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_empty: got %b expected 1", empty); end
    tests_run++; if (dout !== 14'h2000) begin tests_failed++; $display("[TB] FAIL idle_dout: got %h expected 2000", dout); end
  endtask

  task automatic test_show_ahead();
    do_reset();
    wr_en = 1'b1;
    din   = 14'h0001;
    tick();
    tests_run++; if (dout !== 14'h0001) begin tests_failed++; $display("[TB] FAIL sa_first_dout: got %h expected 0001", dout); end
    tests_run++; if (empty !== 1'b0) begin tests_failed++; $display("[TB] FAIL sa_first_empty: got %b expected 0", empty); end
    din = 14'h0002;
    tick();
    din = 14'h0003;
    tick();
    wr_en = 1'b0;
    tests_run++; if (count !== 6'd3) begin tests_failed++; $display("[TB] FAIL sa_count3: got %0d expected 3", count); end
    tests_run++; if (dout !== 14'h0001) begin tests_failed++; $display("[TB] FAIL sa_head_held: got %h expected 0001", dout); end
    rd_en = 1'b1;
    tick();
    tests_run++; if (dout !== 14'h0002) begin tests_failed++; $display("[TB] FAIL sa_pop1: got %h expected 0002", dout); end
    tick();
    tests_run++; if (dout !== 14'h0003) begin tests_failed++; $display("[TB] FAIL sa_pop2: got %h expected 0003", dout); end
    tick();
    rd_en = 1'b0;
    tests_run++; if (dout !== 14'h2000) begin tests_failed++; $display("[TB] FAIL sa_pop3_dout: got %h expected 2000", dout); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL sa_pop3_empty: got %b expected 1", empty); end
  endtask

  task automatic test_above_half();
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      din = 14'(i);
      tick();
    end
    tests_run++; if (count !== 6'd15) begin tests_failed++; $display("[TB] FAIL ah_count15: got %0d expected 15", count); end
    tests_run++; if (above_half !== 1'b0) begin tests_failed++; $display("[TB] FAIL ah_at15: got %b expected 0", above_half); end
    din = 14'd15;
    tick();
    wr_en = 1'b0;
    tests_run++; if (count !== 6'd16) begin tests_failed++; $display("[TB] FAIL ah_count16: got %0d expected 16", count); end
    tests_run++; if (above_half !== 1'b1) begin tests_failed++; $display("[TB] FAIL ah_at16: got %b expected 1", above_half); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests_run++; if (count !== 6'd15) begin tests_failed++; $display("[TB] FAIL ah_pop_count: got %0d expected 15", count); end
    tests_run++; if (above_half !== 1'b0) begin tests_failed++; $display("[TB] FAIL ah_pop_flag: got %b expected 0", above_half); end
  endtask

  task automatic test_full();
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 31; i++) begin
      din = 14'h0100 + 14'(i);
      tick();
    end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_at31: got %b expected 0", full); end
    din = 14'h011F;
    tick();
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_at32: got %b expected 1", full); end
    tests_run++; if (count !== 6'd32) begin tests_failed++; $display("[TB] FAIL full_count32: got %0d expected 32", count); end
    // Overflow: write alone while full is dropped
    din = 14'h3FFF;
    tick();
    tests_run++; if (count !== 6'd32) begin tests_failed++; $display("[TB] FAIL ovf_count: got %0d expected 32", count); end
    tests_run++; if (dout !== 14'h0100) begin tests_failed++; $display("[TB] FAIL ovf_head: got %h expected 0100", dout); end
`ifdef SAMPLE_FIFO_ERR_EN
    tests_run++; if (ovf_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_err_set: got %b expected 1", ovf_err); end
`endif
    // Write plus read while full is accepted
    din   = 14'h0AAA;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tests_run++; if (count !== 6'd32) begin tests_failed++; $display("[TB] FAIL full_rw_count: got %0d expected 32", count); end
    tests_run++; if (dout !== 14'h0101) begin tests_failed++; $display("[TB] FAIL full_rw_head: got %h expected 0101", dout); end
    // Drain: 0x101..0x11F then 0x0AAA, with 0x3FFF never appearing
    for (int i = 0; i < 32; i++) begin
      if (i < 31) begin
        tests_run++; if (dout !== 14'h0101 + 14'(i)) begin tests_failed++; $display("[TB] FAIL full_drain[%0d]: got %h expected %h", i, dout, 14'h0101 + 14'(i)); end
      end else begin
        tests_run++; if (dout !== 14'h0AAA) begin tests_failed++; $display("[TB] FAIL full_drain_last: got %h expected 0aaa", dout); end
      end
      tick();
    end
    rd_en = 1'b0;
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_drain_empty: got %b expected 1", empty); end
  endtask

  // 24-word burst, then one write and one pop every 16 cycles until 40 words
  // have passed through; both pointers wrap the 32-entry array.
  task automatic test_wrap();
    int wi;
    int ri;
    do_reset();
    wi = 0;
    ri = 0;
    for (int c = 0; c < 16 * 40; c++) begin
      wr_en = 1'b0;
      rd_en = 1'b0;
      if (wi < 40 && (c < 24 || (c % 16) == 8)) begin
        wr_en = 1'b1;
        din   = 14'h0500 + 14'(wi);
        wi++;
      end
      if ((c % 16) == 15) begin
        tests_run++; if (dout !== 14'h0500 + 14'(ri)) begin tests_failed++; $display("[TB] FAIL wrap_pop[%0d]: got %h expected %h", ri, dout, 14'h0500 + 14'(ri)); end
        rd_en = 1'b1;
        ri++;
      end
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    tests_run++; if (count !== 6'd0) begin tests_failed++; $display("[TB] FAIL wrap_end_count: got %0d expected 0", count); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_end_empty: got %b expected 1", empty); end
  endtask

  task automatic test_async_reset();
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 14'h0200 + 14'(i);
      tick();
    end
    wr_en = 1'b0;
    tests_run++; if (count !== 6'd10) begin tests_failed++; $display("[TB] FAIL ar_count10: got %0d expected 10", count); end
    // Assert reset mid-cycle, well before the next rising edge
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL ar_empty: got %b expected 1", empty); end
    tests_run++; if (count !== 6'd0) begin tests_failed++; $display("[TB] FAIL ar_count: got %0d expected 0", count); end
    tests_run++; if (dout !== 14'h2000) begin tests_failed++; $display("[TB] FAIL ar_dout: got %h expected 2000", dout); end
    tests_run++; if (above_half !== 1'b0) begin tests_failed++; $display("[TB] FAIL ar_above_half: got %b expected 0", above_half); end
    rst_n = 1'b1;
    // Underflow: a pop while empty changes nothing
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests_run++; if (count !== 6'd0) begin tests_failed++; $display("[TB] FAIL udf_count: got %0d expected 0", count); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL udf_empty: got %b expected 1", empty); end
    tests_run++; if (dout !== 14'h2000) begin tests_failed++; $display("[TB] FAIL udf_dout: got %h expected 2000", dout); end
`ifdef SAMPLE_FIFO_ERR_EN
    tests_run++; if (udf_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL udf_err_set: got %b expected 1", udf_err); end
`endif
    // Writing after the underflow starts cleanly from the reset pointers
    wr_en = 1'b1;
    din   = 14'h1234;
    tick();
    wr_en = 1'b0;
    tests_run++; if (dout !== 14'h1234) begin tests_failed++; $display("[TB] FAIL ar_resume_dout: got %h expected 1234", dout); end
    tests_run++; if (count !== 6'd1) begin tests_failed++; $display("[TB] FAIL ar_resume_count: got %0d expected 1", count); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    test_reset();
    test_show_ahead();
    test_above_half();
    test_full();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
